puf_challenge_evaluator: RTL
============================

Name: puf_challenge_evaluator

Overview:
- Downstream consumer of the scrambler's challenge stream.
- Per run: reseeds the scrambler, samples one scrambled challenge per response bit, drives the PUF core with a req/ack handshake, and evaluates each challenge VOTES times with majority voting.
- Packs the voted bits LSB-first into a RESP_W-bit response, presented on a valid/ready output. This is the stage between the challenge scrambler and the response consumer (key register / host interface).

Parameters:
- CHAL_W, 8, challenge width; equals scrambler width.
- RESP_W, 8, response bits per run (≥1).
- VOTES, 3, evaluations per challenge; odd, ≥1.
- TIMEOUT, 64, max WAIT cycles per evaluation before abort (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- seed  in  CHAL_W  seed value, captured with start
- scr_seed  out  CHAL_W  registered seed, to scrambler input_challenge
- scr_rst  out  1  registered one-cycle pulse, to scrambler rst
- chal_in  in  CHAL_W  scrambler output_challenge
- puf_chal  out  CHAL_W  challenge presented to PUF core
- puf_req  out  1  evaluation request
- puf_ack  in  1  evaluation done
- puf_bit  in  1  PUF response bit, valid with puf_ack
- resp  out  RESP_W  voted response word
- resp_valid  out  1  resp valid
- resp_ready  in  1  consumer accepts resp
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async): state IDLE; all outputs 0; all counters cleared. Reset mid-run aborts without emitting a response.
- All outputs are registered.
- IDLE:
  - start=1 -> scr_seed<=seed, timeout_err<=0, resp<=0, bit_cnt<=0, go SEED.
  - start while busy is ignored.
- SEED: scr_rst=1 for exactly this cycle -> ISSUE.
- ISSUE:
  - puf_chal<=chal_in, sampled on the edge leaving ISSUE.
  - vote_cnt<=0, ones<=0 -> WAIT.
  - puf_chal holds stable for all VOTES evaluations of that bit.
- WAIT:
  - puf_req=1; timeout counter increments each cycle.
  - puf_ack=1 -> ones+=puf_bit, vote_cnt+=1. If vote_cnt now equals VOTES go VOTE, else go REARM.
  - No ack after TIMEOUT WAIT cycles -> timeout_err<=1, go IDLE. No resp_valid is raised; the partial resp is discarded.
  - The timeout counter clears on every WAIT entry.
- REARM: puf_req=0 for one cycle (return-to-zero handshake) -> WAIT.
- puf_ack is ignored in every state except WAIT.
- VOTE:
  - resp[bit_cnt] <= (ones > VOTES/2), bit_cnt+=1.
  - bit_cnt reaches RESP_W -> OUT, else ISSUE.
- OUT:
  - resp_valid=1; resp is held stable.
  - resp_ready=1 -> resp_valid<=0, go IDLE.
  - start in the handshake cycle is ignored; it must be reasserted in IDLE.
  - resp_ready while resp_valid=0 has no effect.
- Latency with puf_ack tied high:
  - Each evaluation takes 1 WAIT cycle; each bit takes 2·VOTES+1 cycles.
  - resp_valid rises 1+RESP_W·(2·VOTES+1) edges after the edge that sampled start: 57 with default parameters.
- Width rules:
  - ones and vote_cnt are clog2(VOTES+1) bits.
  - bit_cnt is clog2(RESP_W+1) bits.
  - The timeout counter is clog2(TIMEOUT+1) bits.
  - No counter wraps.

Test Plan:
- Reset, then idle -> all outputs 0, busy=0; ack pulses with no run active change nothing.
- start, seed=8'hA5, ack tied high, puf_bit=1 -> scr_rst exactly 1 cycle, scr_seed=8'hA5, first puf_chal equals chal_in sampled during ISSUE, resp=8'hFF, resp_valid at edge 57.
- Per-bit puf_bit sequences 1,0,1 / 0,1,0 / 1,1,0 / 0,0,1 repeating -> each bit = majority, resp=8'h55; puf_req drops for exactly 1 cycle between the evaluations of each bit.
- puf_ack never asserted -> timeout_err=1 after 64 WAIT cycles, return to IDLE, no resp_valid; next start clears timeout_err.
- resp_ready held low 10 cycles in OUT -> resp and resp_valid stable throughout; start pulsed during busy and in the handshake cycle -> ignored.
- rst asserted mid-WAIT -> immediate IDLE, puf_req=0, outputs 0; a new run afterwards completes normally.

Source files
------------

// File: rtl/puf_challenge_evaluator.sv
// Reseeds the scrambler, then for each response bit runs VOTES req/ack evaluations and majority-votes them.
// Latency 1+RESP_W*(2*VOTES+1) cycles with a zero-wait PUF; holds resp until resp_ready, aborts on PUF timeout.
module puf_challenge_evaluator #(
   parameter int CHAL_W  = 8,
   parameter int RESP_W  = 8,
   parameter int VOTES   = 3,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CHAL_W-1:0] seed,
   output logic [CHAL_W-1:0] scr_seed,
   output logic              scr_rst,
   input  logic [CHAL_W-1:0] chal_in,
   output logic [CHAL_W-1:0] puf_chal,
   output logic              puf_req,
   input  logic              puf_ack,
   input  logic              puf_bit,
   output logic [RESP_W-1:0] resp,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              busy,
   output logic              timeout_err
);

   localparam int VW = $clog2(VOTES + 1);
   localparam int BW = $clog2(RESP_W + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [VW-1:0] HALF = VW'(VOTES / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_ISSUE, S_WAIT, S_REARM, S_VOTE, S_OUT
   } state_t;

   state_t state_q, state_d;

   logic [CHAL_W-1:0] scr_seed_q, scr_seed_d;
   logic [CHAL_W-1:0] puf_chal_q, puf_chal_d;
   logic [RESP_W-1:0] resp_q, resp_d;
   logic              scr_rst_q, scr_rst_d;
   logic              puf_req_q, puf_req_d;
   logic              resp_valid_q, resp_valid_d;
   logic              busy_q, busy_d;
   logic              terr_q, terr_d;
   logic [VW-1:0]     vote_cnt_q, vote_cnt_d, ones_q, ones_d, vote_nxt;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d, bit_nxt;
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              tmo_hit;

   assign vote_nxt = vote_cnt_q + VW'(1);
   assign bit_nxt  = bit_cnt_q + BW'(1);
   assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SEED;
         S_SEED:  state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (puf_ack)      state_d = (vote_nxt == VW'(VOTES)) ? S_VOTE : S_REARM;
            else if (tmo_hit) state_d = S_IDLE;
         end
         S_REARM: state_d = S_WAIT;
         S_VOTE:  state_d = (bit_nxt == BW'(RESP_W)) ? S_OUT : S_ISSUE;
         S_OUT:   if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one is valid in the cycle its state is active.
   always_comb begin
      scr_seed_d = scr_seed_q;
      puf_chal_d = puf_chal_q;
      resp_d     = resp_q;
      terr_d     = terr_q;
      vote_cnt_d = vote_cnt_q;
      ones_d     = ones_q;
      bit_cnt_d  = bit_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               scr_seed_d = seed;
               terr_d     = 1'b0;
               resp_d     = '0;
               bit_cnt_d  = '0;
            end
         end
         S_ISSUE: begin
            puf_chal_d = chal_in;
            vote_cnt_d = '0;
            ones_d     = '0;
            tmo_cnt_d  = '0;
         end
         S_WAIT: begin
            if (puf_ack) begin
               ones_d     = ones_q + VW'(puf_bit);
               vote_cnt_d = vote_nxt;
            end else if (tmo_hit) begin
               terr_d = 1'b1;
               resp_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         S_REARM: tmo_cnt_d = '0;
         S_VOTE: begin
            if (ones_q > HALF) resp_d = resp_q | (RESP_W'(1) << bit_cnt_q);
            bit_cnt_d = bit_nxt;
         end
         default: ;
      endcase
      scr_rst_d    = (state_d == S_SEED);
      puf_req_d    = (state_d == S_WAIT);
      resp_valid_d = (state_d == S_OUT);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scr_seed_q   <= '0;
         puf_chal_q   <= '0;
         resp_q       <= '0;
         scr_rst_q    <= 1'b0;
         puf_req_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         terr_q       <= 1'b0;
         vote_cnt_q   <= '0;
         ones_q       <= '0;
         bit_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         scr_seed_q   <= scr_seed_d;
         puf_chal_q   <= puf_chal_d;
         resp_q       <= resp_d;
         scr_rst_q    <= scr_rst_d;
         puf_req_q    <= puf_req_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         terr_q       <= terr_d;
         vote_cnt_q   <= vote_cnt_d;
         ones_q       <= ones_d;
         bit_cnt_q    <= bit_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign scr_seed    = scr_seed_q;
   assign scr_rst     = scr_rst_q;
   assign puf_chal    = puf_chal_q;
   assign puf_req     = puf_req_q;
   assign resp        = resp_q;
   assign resp_valid  = resp_valid_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule
